// File: rtl/mac_operand_issuer.sv
// Operand sequencer for one MAC pass: fetch N_TERMS weight/input pairs, strobe each to the MAC,
// wait for the term counter, clear it, pulse done. Optional watchdog: MAC_ISSUER_TIMEOUT_EN.
module mac_operand_issuer #(
  parameter int N_TERMS = 3,
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,      // asynchronous, active-low
  input  logic              i_start,
  input  logic              i_hold,
  input  logic [DATA_W-1:0] i_w_in,
  input  logic [DATA_W-1:0] i_x_in,
  input  logic              i_ack__mac,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_mac_a,
  output logic [DATA_W-1:0] o_mac_b,
  output logic              o_ack,
  output logic              o_clr_cnt,
  output logic              o_busy,
  output logic              o_done
`ifdef MAC_ISSUER_TIMEOUT_EN
  ,
  output logic              o_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_MAC = 3'd3,
    S_FIN      = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_TERMS - 1);

  // Reject configurations where the index could wrap or the watchdog could never fire.
  if (N_TERMS < 1 || N_TERMS > (1 << ADDR_W) || TIMEOUT < 1) begin : g_bad_params
    $error("mac_operand_issuer: illegal N_TERMS/ADDR_W/TIMEOUT combination");
  end

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_mac_a, w_mac_a_nxt;
  logic [DATA_W-1:0] r_mac_b, w_mac_b_nxt;
  logic              r_ack, w_ack_nxt;
  logic              r_clr_cnt;
  logic              r_busy;
  logic              r_done;
  logic              w_fin_nxt;

`ifdef MAC_ISSUER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic             r_err, w_err_nxt;
`endif

  // Next-state, operand capture and strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_addr_nxt  = r_addr;
    w_mac_a_nxt = r_mac_a;
    w_mac_b_nxt = r_mac_b;
    w_ack_nxt   = 1'b0;
`ifdef MAC_ISSUER_TIMEOUT_EN
    w_wait_cnt_nxt = {CNT_W{1'b0}};
    w_err_nxt      = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_FETCH;
          w_idx_nxt   = {ADDR_W{1'b0}};
          w_addr_nxt  = {ADDR_W{1'b0}};
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (i_hold) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_hold) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_mac_a_nxt = i_w_in;
          w_mac_b_nxt = i_x_in;
          w_ack_nxt   = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_WAIT_MAC;
          end else begin
            w_idx_nxt   = r_idx + ADDR_W'(1);
            w_addr_nxt  = r_addr + ADDR_W'(1);
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_WAIT_MAC: begin
        if (i_ack__mac) begin
          w_state_nxt = S_FIN;
`ifdef MAC_ISSUER_TIMEOUT_EN
        end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_state_nxt = S_FIN;
          w_err_nxt   = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
`else
        end else begin
          w_state_nxt = S_WAIT_MAC;
        end
`endif
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_fin_nxt = (w_state_nxt == S_FIN);
  end

  // State and registered outputs; everything advances on the falling clock edge.
  always_ff @(negedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= S_IDLE;
      r_idx     <= {ADDR_W{1'b0}};
      r_addr    <= {ADDR_W{1'b0}};
      r_mac_a   <= {DATA_W{1'b0}};
      r_mac_b   <= {DATA_W{1'b0}};
      r_ack     <= 1'b0;
      r_clr_cnt <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef MAC_ISSUER_TIMEOUT_EN
      r_wait_cnt <= {CNT_W{1'b0}};
      r_err      <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_addr    <= w_addr_nxt;
      r_mac_a   <= w_mac_a_nxt;
      r_mac_b   <= w_mac_b_nxt;
      r_ack     <= w_ack_nxt;
      r_clr_cnt <= w_fin_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= w_fin_nxt;
`ifdef MAC_ISSUER_TIMEOUT_EN
      r_wait_cnt <= w_wait_cnt_nxt;
      r_err      <= w_err_nxt;
`endif
    end
  end

  assign o_addr    = r_addr;
  assign o_mac_a   = r_mac_a;
  assign o_mac_b   = r_mac_b;
  assign o_ack     = r_ack;
  assign o_clr_cnt = r_clr_cnt;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
`ifdef MAC_ISSUER_TIMEOUT_EN
  assign o_err     = r_err;
`endif

endmodule

// File: tb/tb_mac_operand_issuer.sv
// Scoreboard bench for mac_operand_issuer: expected operand strobes are queued at launch and
// checked by a monitor as the DUT emits them; each scenario task checks its own control outputs.
module tb_mac_operand_issuer;
  localparam int N_TERMS = 3;
  localparam int ADDR_W  = 2;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b1;
  logic              rst;
  logic              start;
  logic              hold;
  logic              ack_mac;
  logic [DATA_W-1:0] w_in;
  logic [DATA_W-1:0] x_in;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_b;
  logic              ack;
  logic              clr_cnt;
  logic              busy;
  logic              done;
`ifdef MAC_ISSUER_TIMEOUT_EN
  logic              err;
`endif

  mac_operand_issuer #(
    .N_TERMS(N_TERMS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_hold(hold),
    .i_w_in(w_in), .i_x_in(x_in), .i_ack__mac(ack_mac),
    .o_addr(addr), .o_mac_a(mac_a), .o_mac_b(mac_b), .o_ack(ack),
    .o_clr_cnt(clr_cnt), .o_busy(busy), .o_done(done)
`ifdef MAC_ISSUER_TIMEOUT_EN
    , .o_err(err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ecount   = 0;
  int base     = 0;

  typedef struct {
    int               cyc;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } exp_t;
  exp_t exp_q[$];

  // Active edge counter; cycle c of a pass is the interval after the c-th edge past the start sample.
  always @(negedge clk) ecount++;

  // Synchronous-read operand memories: w = addr+1, x = addr+10, one cycle latency.
  always @(negedge clk) begin
    w_in <= DATA_W'(addr) + 16'd1;
    x_in <= DATA_W'(addr) + 16'd10;
  end

  // Scoreboard: every strobe must match the next queued (cycle, weight, input) triple.
  always @(posedge clk) begin
    exp_t e;
    if (ack === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: cycle %0d a=%0d b=%0d, required no strobe", ecount - base, mac_a, mac_b);
      end else begin
        e = exp_q.pop_front();
        if ((ecount - base) != e.cyc || mac_a !== e.a || mac_b !== e.b) begin
          n_fail++;
          $display("FAIL ack_operands: got cycle %0d a=%0d b=%0d, required cycle %0d a=%0d b=%0d",
                   ecount - base, mac_a, mac_b, e.cyc, e.a, e.b);
        end
      end
    end
  end

  task automatic push_exp(input int c, input int a, input int b);
    exp_t e;
    e.cyc = c;
    e.a   = DATA_W'(a);
    e.b   = DATA_W'(b);
    exp_q.push_back(e);
  endtask

  task automatic launch();
    @(posedge clk);
    start = 1'b1;
    @(negedge clk);
    #1;
    base  = ecount;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; hold = 1'b0; ack_mac = 1'b0;
    #2;
    n_checks++;
    if ({addr, mac_a, mac_b, ack, clr_cnt, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: addr=%0d a=%0d b=%0d ack=%b clr=%b busy=%b done=%b, required all 0",
               addr, mac_a, mac_b, ack, clr_cnt, busy, done);
    end
`ifdef MAC_ISSUER_TIMEOUT_EN
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: got %b required 0", err);
    end
`endif
    repeat (3) @(posedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0/0", busy, done);
    end
  endtask

  task automatic test_basic();
    logic e_busy, e_fin;
    push_exp(2, 1, 10); push_exp(4, 2, 11); push_exp(6, 3, 12);
    launch();
    for (int c = 0; c <= 10; c++) begin
      @(posedge clk);
      e_busy = (c <= 8);
      e_fin  = (c == 8);
      n_checks++;
      if (busy !== e_busy || done !== e_fin || clr_cnt !== e_fin) begin
        n_fail++;
        $display("FAIL basic_ctrl: cycle %0d got busy=%b done=%b clr=%b, required %b/%b/%b",
                 c, busy, done, clr_cnt, e_busy, e_fin, e_fin);
      end
      ack_mac = (c == 7);
    end
    ack_mac = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_missing_acks: got %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_hold();
    logic e_busy, e_fin;
    push_exp(2, 1, 10); push_exp(6, 2, 11); push_exp(8, 3, 12);
    launch();
    for (int c = 0; c <= 12; c++) begin
      @(posedge clk);
      e_busy = (c <= 10);
      e_fin  = (c == 10);
      n_checks++;
      if (busy !== e_busy || done !== e_fin) begin
        n_fail++;
        $display("FAIL hold_ctrl: cycle %0d got busy=%b done=%b, required %b/%b", c, busy, done, e_busy, e_fin);
      end
      if (c == 4 || c == 5) begin
        n_checks++;
        if (mac_a !== 16'd1 || mac_b !== 16'd10 || ack !== 1'b0) begin
          n_fail++;
          $display("FAIL hold_stall: cycle %0d got a=%0d b=%0d ack=%b, required 1/10/0", c, mac_a, mac_b, ack);
        end
      end
      hold    = (c == 3 || c == 4);
      ack_mac = (c == 9);
    end
    hold = 1'b0; ack_mac = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL hold_missing_acks: got %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_start_ignored();
    logic e_busy, e_fin;
    int   n_done = 0;
    push_exp(2, 1, 10); push_exp(4, 2, 11); push_exp(6, 3, 12);
    launch();
    for (int c = 0; c <= 12; c++) begin
      @(posedge clk);
      e_busy = (c <= 7);
      e_fin  = (c == 7);
      if (done === 1'b1) n_done++;
      n_checks++;
      if (busy !== e_busy || done !== e_fin) begin
        n_fail++;
        $display("FAIL start_ignored_ctrl: cycle %0d got busy=%b done=%b, required %b/%b", c, busy, done, e_busy, e_fin);
      end
      start   = (c == 3 || c == 7);
      ack_mac = (c == 6);
    end
    start = 1'b0; ack_mac = 1'b0;
    n_checks++;
    if (n_done != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL start_ignored_passes: got %0d done pulses, %0d outstanding acks, required 1/0", n_done, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_rst_abort();
    push_exp(2, 1, 10); push_exp(4, 2, 11); push_exp(6, 3, 12);
    launch();
    for (int c = 0; c <= 7; c++) @(posedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({addr, mac_a, mac_b, ack, clr_cnt, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL abort_async: addr=%0d a=%0d b=%0d ack=%b clr=%b busy=%b done=%b, required all 0",
               addr, mac_a, mac_b, ack, clr_cnt, busy, done);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done: got done=%b busy=%b, required 0/0", done, busy);
      end
    end
    rst = 1'b1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_acks: got %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_ack_early();
    logic e_busy, e_fin;
    ack_mac = 1'b1;
    push_exp(2, 1, 10); push_exp(4, 2, 11); push_exp(6, 3, 12);
    launch();
    for (int c = 0; c <= 9; c++) begin
      @(posedge clk);
      e_busy = (c <= 7);
      e_fin  = (c == 7);
      n_checks++;
      if (busy !== e_busy || done !== e_fin || clr_cnt !== e_fin) begin
        n_fail++;
        $display("FAIL ack_early_ctrl: cycle %0d got busy=%b done=%b clr=%b, required %b/%b/%b",
                 c, busy, done, clr_cnt, e_busy, e_fin, e_fin);
      end
      ack_mac = (c < 8);
    end
    ack_mac = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ack_early_acks: got %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

`ifdef MAC_ISSUER_TIMEOUT_EN
  task automatic test_timeout();
    logic e_busy, e_fin, e_err;
    push_exp(2, 1, 10); push_exp(4, 2, 11); push_exp(6, 3, 12);
    launch();
    for (int c = 0; c <= 24; c++) begin
      @(posedge clk);
      e_busy = (c <= 21);
      e_fin  = (c == 21);
      e_err  = (c >= 21);
      n_checks++;
      if (busy !== e_busy || done !== e_fin || err !== e_err) begin
        n_fail++;
        $display("FAIL timeout_ctrl: cycle %0d got busy=%b done=%b err=%b, required %b/%b/%b",
                 c, busy, done, err, e_busy, e_fin, e_err);
      end
    end
    test_basic();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: got err=%b, required 1", err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_start_ignored();
    test_rst_abort();
    test_basic();
    test_ack_early();
`ifdef MAC_ISSUER_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_operand_issuer.md
# mac_operand_issuer

Sequencer on the initiating side of the `ack` / `ack__mac` handshake used inside each gate's layer. On `start` it reads `N_TERMS` weight/input pairs from the layer's operand memories. It presents each pair to the MAC with a one-cycle `ack` strobe, which the layer's term counter counts. It then waits for the counter's `ack__mac`, clears the counter, and signals `done`. It sits between the layer controller and the MAC/counter pair of, for example, the forget-gate sigmoid layer.

## Interface
Parameters:
- `N_TERMS`, 3: operand pairs per MAC pass; must equal the paired counter's terminal count plus 1.
- `ADDR_W`, 2: operand memory address width; 2^ADDR_W ≥ N_TERMS.
- `DATA_W`, 16: operand width.
- `TIMEOUT`, 15: watchdog limit in cycles. Used only with `MAC_ISSUER_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock. All state updates on the falling edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a pass. Sampled in IDLE only.
- `hold` in 1: stall. Freezes FETCH/ISSUE progress.
- `w_in` in DATA_W: weight memory read data. Valid one cycle after `addr`.
- `x_in` in DATA_W: input memory read data. Valid one cycle after `addr`.
- `ack__mac` in 1: completion from the term counter.
- `addr` out ADDR_W: operand memory address.
- `mac_a` out DATA_W: weight operand to the MAC.
- `mac_b` out DATA_W: input operand to the MAC.
- `ack` out 1: one-cycle strobe, operands valid.
- `clr_cnt` out 1: one-cycle pulse, drives the counter's synchronous active-high `rst`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse, pass complete.
- `err` out 1: watchdog error, sticky. Exists only with `MAC_ISSUER_TIMEOUT_EN`.

## Operation
- States: IDLE, FETCH, ISSUE, WAIT_MAC, FIN.
- IDLE:
  - `start`=1 → FETCH, with `addr`<=0 and the term index `idx`<=0.
  - `start` is ignored in all other states.
- FETCH: `addr` holds `idx`.
  - `hold`=0 → ISSUE.
  - `hold`=1 → stay in FETCH.
- ISSUE (`hold`=0):
  - Capture `mac_a`<=`w_in`, `mac_b`<=`x_in`.
  - `ack`=1 for this cycle only.
  - If `idx`==N_TERMS-1 → WAIT_MAC.
  - Otherwise `idx`+=1, `addr`+=1 → FETCH.
- ISSUE (`hold`=1): stay in ISSUE, `ack`=0, operand registers unchanged.
- WAIT_MAC: `ack`=0. `ack__mac`=1 → FIN.
- FIN: `clr_cnt`=1 and `done`=1 for one cycle → IDLE.
- `mac_a` and `mac_b` hold their last values between strobes.
- `addr` holds its last value in IDLE.
- Index arithmetic is unsigned, ADDR_W bits, and never wraps within a pass, because N_TERMS ≤ 2^ADDR_W.

## Timing
- Reset values:
  - `addr`=0, `mac_a`=0, `mac_b`=0.
  - `ack`=0, `clr_cnt`=0, `busy`=0, `done`=0, `err`=0.
  - State = IDLE.
- Asserting `rst` mid-pass aborts immediately: all outputs go to reset values and no `done` is issued.
- Unstalled pass: exactly 2·N_TERMS cycles from the `start` sample edge to the last `ack`. `ack` is high on cycles 2, 4, …, 2N.
- `done` is high on the cycle after the first cycle in which `ack__mac` is sampled high in WAIT_MAC.
- An `ack__mac` that is already high on entering WAIT_MAC counts immediately.
- `ack__mac` outside WAIT_MAC is ignored.
- Each `hold` cycle adds exactly one cycle. Memory reads are assumed to have fixed 1-cycle latency.
- `start`=1 in the FIN cycle is ignored. `start` is next sampled in IDLE.

## Configuration
- `MAC_ISSUER_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT_MAC.
  - If `ack__mac` has not arrived after TIMEOUT cycles: `err`<=1, the block goes to FIN, and `clr_cnt` and `done` pulse normally.
  - `err` stays high until `rst`.
- Not defined: no `err` port and no counter. WAIT_MAC waits indefinitely.

## Test plan
- Reset, then `start` pulse with N_TERMS=3, `hold`=0, and memories returning w=addr+1, x=addr+10:
  - `ack` high on cycles 2, 4, 6.
  - `mac_a`/`mac_b` = 1/10, 2/11, 3/12.
  - `ack__mac` returned on cycle 7 → `done` and `clr_cnt` on cycle 8.
  - `busy` low on cycle 9.
- `hold`=1 for 2 cycles during the second ISSUE: the second `ack` moves from cycle 4 to cycle 6; operands are unchanged while stalled.
- `start` pulsed during ISSUE and during FIN: ignored, exactly one pass completes.
- `rst` asserted in WAIT_MAC: all outputs are 0 asynchronously and no `done`. A fresh `start` after release runs a full normal pass.
- `ack__mac` held high before WAIT_MAC: ignored until WAIT_MAC, then `done` on the next cycle.
- With `MAC_ISSUER_TIMEOUT_EN` and TIMEOUT=15, `ack__mac` never asserted: `err`=1 and `done` pulse after 15 WAIT_MAC cycles; `err` stays high through the next pass.
